wb_scoreboard: RTL and testbench

- Writer-side companion to the 32x32 register file.
- Arbitrates register writeback between two sources:
  - the single-cycle ALU path, which has no backpressure;
  - a long-latency path (load/divide), which uses a valid/ready handshake and a small FIFO.
- Drives the register file's write port (address, data, write enable).
- Keeps a per-register pending scoreboard so decode stalls on RAW/WAW hazards against outstanding long-latency results.

---
 rtl/core_pkg.sv | 18 +
 rtl/wb_scoreboard_if.sv | 41 ++++
 rtl/wb_fifo.sv | 66 ++++++
 rtl/wb_scoreboard.sv | 97 +++++++++
 tb/tb_wb_scoreboard.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core definitions for the writeback path.
//   XLEN        - integer register width
//   REG_ADDR_W  - architectural register index width
//   X0          - index of the hardwired-zero register
//   wb_entry_t  - one queued long-latency writeback {rd, data}
package core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_scoreboard_if.sv
// Writeback bus between the execution units and wb_scoreboard.
//   ALU request     : i_alu_wren, i_alu_rd, i_alu_data (no backpressure)
//   Long-latency    : i_ll_valid, o_ll_ready, i_ll_rd, i_ll_data
//   Register write  : o_rd_addr, o_rd_data, o_rd_wren
//
// Long-latency handshake: a transfer happens on the rising clock edge where
// i_ll_valid and o_ll_ready are both high. Once i_ll_valid is raised the
// producer holds i_ll_valid, i_ll_rd and i_ll_data stable until that edge.
// o_ll_ready never depends combinationally on i_ll_valid.
//
// Modports: master = execution units / testbench, slave = wb_scoreboard.
interface wb_scoreboard_if;

    logic                              i_alu_wren;
    logic [core_pkg::REG_ADDR_W-1:0]   i_alu_rd;
    logic [core_pkg::XLEN-1:0]         i_alu_data;

    logic                              i_ll_valid;
    logic                              o_ll_ready;
    logic [core_pkg::REG_ADDR_W-1:0]   i_ll_rd;
    logic [core_pkg::XLEN-1:0]         i_ll_data;

    logic [core_pkg::REG_ADDR_W-1:0]   o_rd_addr;
    logic [core_pkg::XLEN-1:0]         o_rd_data;
    logic                              o_rd_wren;

    modport master (
        output i_alu_wren, i_alu_rd, i_alu_data,
        output i_ll_valid, i_ll_rd, i_ll_data,
        input  o_ll_ready,
        input  o_rd_addr, o_rd_data, o_rd_wren
    );

    modport slave (
        input  i_alu_wren, i_alu_rd, i_alu_data,
        input  i_ll_valid, i_ll_rd, i_ll_data,
        output o_ll_ready,
        output o_rd_addr, o_rd_data, o_rd_wren
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular FIFO of pending long-latency writebacks.
//   i_clk, i_reset_n : clock, async active-low reset (empties the FIFO)
//   i_push, i_push_entry : enqueue (ignored when full)
//   i_pop            : dequeue head (ignored when empty)
//   o_full, o_empty  : status from the registered count
//   o_head           : current head entry
module wb_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      i_clk,
    input  logic      i_reset_n,
    input  logic      i_push,
    input  wb_entry_t i_push_entry,
    input  logic      i_pop,
    output logic      o_full,
    output logic      o_empty,
    output wb_entry_t o_head
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full  = (count == FULL_CNT);
    assign o_empty = (count == '0);
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;
    assign o_head  = mem[rd_ptr];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= i_push_entry;
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Register-file writeback arbiter and pending-result scoreboard.
//   i_clk, i_reset_n       : clock, async active-low reset
//   i_issue_valid/_rd      : decode issues a long-latency op to rd
//   i_dec_rs1/_rs2/_rd     : operands of the instruction in decode
//   o_stall                : decode must hold (hazard on a pending register)
//   bus (slave)            : ALU request, long-latency handshake, RF write port
// The ALU always wins the write port; queued long-latency results drain
// in acceptance order whenever the ALU is not writing.
module wb_scoreboard
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int NREG  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_issue_valid,
    input  logic [REG_ADDR_W-1:0] i_issue_rd,
    input  logic [REG_ADDR_W-1:0] i_dec_rs1,
    input  logic [REG_ADDR_W-1:0] i_dec_rs2,
    input  logic [REG_ADDR_W-1:0] i_dec_rd,
    output logic                  o_stall,
    wb_scoreboard_if.slave        bus
);

    wb_entry_t             head;
    wb_entry_t             push_entry;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  alu_win;
    logic                  issue_set;
    logic [NREG-1:0]       pending;
    logic [NREG-1:0]       pending_next;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [XLEN-1:0]       wb_data;
    logic                  wb_wren;

    assign push_entry = '{rd: bus.i_ll_rd, data: bus.i_ll_data};
    // Ready comes only from the registered count, so a pop in a full cycle
    // does not open the door for a push in that same cycle.
    assign push       = bus.i_ll_valid && !full;
    assign alu_win    = bus.i_alu_wren && (bus.i_alu_rd != X0);
    assign pop        = !alu_win && !empty;
    assign issue_set  = i_issue_valid && (i_issue_rd != X0) && !o_stall;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_push       (push),
        .i_push_entry (push_entry),
        .i_pop        (pop),
        .o_full       (full),
        .o_empty      (empty),
        .o_head       (head)
    );

    // Entries for x0 still drain through the port, just without a write.
    always_comb begin
        wb_wren = 1'b0;
        wb_addr = X0;
        wb_data = '0;
        if (alu_win) begin
            wb_wren = 1'b1;
            wb_addr = bus.i_alu_rd;
            wb_data = bus.i_alu_data;
        end else if (!empty) begin
            wb_wren = (head.rd != X0);
            wb_addr = head.rd;
            wb_data = head.data;
        end
    end

    assign bus.o_rd_wren  = wb_wren;
    assign bus.o_rd_addr  = wb_addr;
    assign bus.o_rd_data  = wb_data;
    assign bus.o_ll_ready = !full;

    // Clear before set so a same-cycle set on the same register wins.
    always_comb begin
        pending_next = pending;
        if (pop && (head.rd != X0)) pending_next[head.rd] = 1'b0;
        if (issue_set)              pending_next[i_issue_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) pending <= '0;
        else            pending <= pending_next;
    end

    // Stall holds through the write cycle itself; the register file read
    // only sees the new value on the following cycle.
    assign o_stall = pending[i_dec_rs1] | pending[i_dec_rs2] | pending[i_dec_rd];

endmodule

// File: tb/tb_wb_scoreboard.sv
module tb_wb_scoreboard;

  localparam int DEPTH = 2;
  localparam int W     = 37;  // {rd[4:0], data[31:0]}

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        stall;

  int total_cnt = 0;
  int pass_cnt  = 0;

  logic [W-1:0] exp_q[$];

  wb_scoreboard_if bus();

  wb_scoreboard #(.DEPTH(DEPTH), .NREG(32)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_issue_valid (issue_valid),
    .i_issue_rd    (issue_rd),
    .i_dec_rs1     (dec_rs1),
    .i_dec_rs2     (dec_rs2),
    .i_dec_rd      (dec_rd),
    .o_stall       (stall),
    .bus           (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("watchdog expired, stopping");
    $fatal(1, "watchdog expired");
  end

  // A pending bit being set and cleared in the same cycle means the stall
  // rule was broken by the stimulus.
  always @(posedge clk) begin
    if (rst_n && issue_valid && issue_rd != 5'd0 && !stall && bus.o_rd_wren &&
        !(bus.i_alu_wren && bus.i_alu_rd != 5'd0) && bus.o_rd_addr == issue_rd) begin
      total_cnt++;
      $display("FAIL set_clear_collision rd=%0d at %0t", issue_rd, $time);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = 5'd0;
    dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
    bus.i_alu_wren = 1'b0; bus.i_alu_rd = 5'd0; bus.i_alu_data = '0;
    bus.i_ll_valid = 1'b0; bus.i_ll_rd = 5'd0; bus.i_ll_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_rd = rd; dec_rd = rd;
    tick();
    issue_valid = 1'b0; issue_rd = 5'd0; dec_rd = 5'd0;
  endtask

  task automatic alu(input logic en, input logic [4:0] rd, input logic [31:0] d);
    bus.i_alu_wren = en; bus.i_alu_rd = rd; bus.i_alu_data = d;
  endtask

  task automatic ll(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.i_ll_valid = v; bus.i_ll_rd = rd; bus.i_ll_data = d;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.o_ll_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.o_ll_ready); else pass_cnt++;
    total_cnt++; if (bus.o_rd_wren !== 1'b0) $display("FAIL reset_wren got=%b exp=0", bus.o_rd_wren); else pass_cnt++;
    total_cnt++; if (bus.o_rd_addr !== 5'd0 || bus.o_rd_data !== 32'd0)
      $display("FAIL reset_addr_data got=%0d/%h exp=0/0", bus.o_rd_addr, bus.o_rd_data); else pass_cnt++;
    total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    issue(5'd5);
    dec_rs1 = 5'd5;
    @(negedge clk);
    total_cnt++; if (stall !== 1'b1) $display("FAIL issue_stall got=%b exp=1", stall); else pass_cnt++;
    tick();
  endtask

  task automatic test_ll_write();
    do_reset();
    issue(5'd5);
    dec_rs1 = 5'd5;
    ll(1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    total_cnt++; if (bus.o_rd_wren !== 1'b0) $display("FAIL ll_no_bypass wren got=%b exp=0", bus.o_rd_wren); else pass_cnt++;
    tick();
    ll(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    total_cnt++; if (bus.o_rd_wren !== 1'b1 || bus.o_rd_addr !== 5'd5 || bus.o_rd_data !== 32'hDEADBEEF)
      $display("FAIL ll_write got=%b/%0d/%h exp=1/5/deadbeef", bus.o_rd_wren, bus.o_rd_addr, bus.o_rd_data); else pass_cnt++;
    total_cnt++; if (stall !== 1'b1) $display("FAIL ll_write_stall got=%b exp=1", stall); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++; if (stall !== 1'b0 || bus.o_rd_wren !== 1'b0)
      $display("FAIL ll_after_write stall/wren got=%b/%b exp=0/0", stall, bus.o_rd_wren); else pass_cnt++;
    tick();
  endtask

  task automatic test_alu_priority();
    do_reset();
    issue(5'd7);
    alu(1'b1, 5'd3, 32'h22);
    ll(1'b1, 5'd7, 32'h11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++; if (bus.o_rd_wren !== 1'b1 || bus.o_rd_addr !== 5'd3 || bus.o_rd_data !== 32'h22)
        $display("FAIL alu_wins cyc=%0d got=%b/%0d/%h exp=1/3/22", i, bus.o_rd_wren, bus.o_rd_addr, bus.o_rd_data); else pass_cnt++;
      tick();
      ll(1'b0, 5'd0, 32'd0);
    end
    alu(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    total_cnt++; if (bus.o_rd_wren !== 1'b1 || bus.o_rd_addr !== 5'd7 || bus.o_rd_data !== 32'h11)
      $display("FAIL ll_after_alu got=%b/%0d/%h exp=1/7/11", bus.o_rd_wren, bus.o_rd_addr, bus.o_rd_data); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++; if (bus.o_rd_wren !== 1'b0) $display("FAIL alu_idle wren got=%b exp=0", bus.o_rd_wren); else pass_cnt++;
    tick();
  endtask

  task automatic test_fifo_full();
    do_reset();
    issue(5'd4); issue(5'd6); issue(5'd8);
    alu(1'b1, 5'd9, 32'h99);
    ll(1'b1, 5'd4, 32'hA);
    @(negedge clk);
    total_cnt++; if (bus.o_ll_ready !== 1'b1) $display("FAIL full_ready0 got=%b exp=1", bus.o_ll_ready); else pass_cnt++;
    tick();
    ll(1'b1, 5'd6, 32'hB);
    @(negedge clk);
    total_cnt++; if (bus.o_ll_ready !== 1'b1) $display("FAIL full_ready1 got=%b exp=1", bus.o_ll_ready); else pass_cnt++;
    tick();
    ll(1'b1, 5'd8, 32'hC);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++; if (bus.o_ll_ready !== 1'b0 || bus.o_rd_addr !== 5'd9)
        $display("FAIL full_hold cyc=%0d ready/addr got=%b/%0d exp=0/9", i, bus.o_ll_ready, bus.o_rd_addr); else pass_cnt++;
      tick();
    end
    alu(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    total_cnt++; if (bus.o_rd_wren !== 1'b1 || bus.o_rd_addr !== 5'd4 || bus.o_rd_data !== 32'hA || bus.o_ll_ready !== 1'b0)
      $display("FAIL full_pop1 got=%b/%0d/%h rdy=%b exp=1/4/a rdy=0", bus.o_rd_wren, bus.o_rd_addr, bus.o_rd_data, bus.o_ll_ready); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++; if (bus.o_rd_wren !== 1'b1 || bus.o_rd_addr !== 5'd6 || bus.o_rd_data !== 32'hB || bus.o_ll_ready !== 1'b1)
      $display("FAIL full_pop2 got=%b/%0d/%h rdy=%b exp=1/6/b rdy=1", bus.o_rd_wren, bus.o_rd_addr, bus.o_rd_data, bus.o_ll_ready); else pass_cnt++;
    tick();
    ll(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    total_cnt++; if (bus.o_rd_wren !== 1'b1 || bus.o_rd_addr !== 5'd8 || bus.o_rd_data !== 32'hC)
      $display("FAIL full_pop3 got=%b/%0d/%h exp=1/8/c", bus.o_rd_wren, bus.o_rd_addr, bus.o_rd_data); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++; if (bus.o_rd_wren !== 1'b0 || bus.o_ll_ready !== 1'b1)
      $display("FAIL full_drained wren/ready got=%b/%b exp=0/1", bus.o_rd_wren, bus.o_ll_ready); else pass_cnt++;
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    alu(1'b1, 5'd0, 32'hFFFF);
    @(negedge clk);
    total_cnt++; if (bus.o_rd_wren !== 1'b0) $display("FAIL alu_x0 wren got=%b exp=0", bus.o_rd_wren); else pass_cnt++;
    tick();
    alu(1'b0, 5'd0, 32'd0);
    issue(5'd2);
    ll(1'b1, 5'd0, 32'h1);
    tick();
    ll(1'b0, 5'd0, 32'd0);
    dec_rs1 = 5'd2;
    @(negedge clk);
    total_cnt++; if (bus.o_rd_wren !== 1'b0) $display("FAIL ll_x0 wren got=%b exp=0", bus.o_rd_wren); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++; if (stall !== 1'b1 || bus.o_rd_wren !== 1'b0)
      $display("FAIL ll_x0_pending stall/wren got=%b/%b exp=1/0", stall, bus.o_rd_wren); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(5'd4); issue(5'd6);
    alu(1'b1, 5'd9, 32'h99);
    ll(1'b1, 5'd4, 32'hA); tick();
    ll(1'b1, 5'd6, 32'hB); tick();
    #2;
    idle_inputs();
    dec_rs1 = 5'd4; dec_rs2 = 5'd6;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.o_rd_wren !== 1'b0 || bus.o_rd_addr !== 5'd0 || bus.o_rd_data !== 32'd0 || bus.o_ll_ready !== 1'b1 || stall !== 1'b0)
      $display("FAIL mid_reset got wren=%b addr=%0d data=%h rdy=%b stall=%b exp 0/0/0/1/0",
               bus.o_rd_wren, bus.o_rd_addr, bus.o_rd_data, bus.o_ll_ready, stall); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      total_cnt++; if (bus.o_rd_wren !== 1'b0 || stall !== 1'b0)
        $display("FAIL post_reset cyc=%0d wren/stall got=%b/%b exp=0/0", i, bus.o_rd_wren, stall); else pass_cnt++;
    end
    tick();
  endtask

  // ---------------- randomized test with reference model ----------------
  // Model: exp_q is the ordered list of accepted long-latency results,
  // pend_m the set of registers awaiting a result, iss_q the issued ops
  // the producer still owes.
  task automatic test_random();
    bit [31:0]    pend_m;
    logic [4:0]   iss_q[$];
    logic [W-1:0] head;
    bit           prod_valid;
    logic [4:0]   prod_rd;
    logic [31:0]  prod_data;
    bit           stall_m, ready_m, alu_win_m, quiet;
    logic         e_wren;
    logic [4:0]   e_addr;
    logic [31:0]  e_data;

    do_reset();
    exp_q.delete();
    pend_m = '0;
    prod_valid = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      quiet = (cyc >= 500);
      if (!prod_valid && iss_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        prod_valid = 1'b1;
        prod_rd = iss_q.pop_front();
        prod_data = $urandom;
      end
      dec_rs1 = 5'($urandom_range(0, 7));
      dec_rs2 = 5'($urandom_range(0, 7));
      dec_rd  = 5'($urandom_range(0, 7));
      stall_m = pend_m[dec_rs1] | pend_m[dec_rs2] | pend_m[dec_rd];
      issue_valid = !quiet && ($urandom_range(0, 2) == 0);
      issue_rd = dec_rd;
      bus.i_alu_wren = ($urandom_range(0, 1) == 1);
      bus.i_alu_rd = 5'($urandom_range(0, 15));
      if (pend_m[bus.i_alu_rd]) bus.i_alu_rd = bus.i_alu_rd + 5'd8;
      bus.i_alu_data = $urandom;
      ll(prod_valid, prod_valid ? prod_rd : 5'd0, prod_valid ? prod_data : 32'd0);

      alu_win_m = bus.i_alu_wren && bus.i_alu_rd != 5'd0;
      ready_m = exp_q.size() < DEPTH;
      e_wren = 1'b0; e_addr = 5'd0; e_data = 32'd0;
      if (alu_win_m) begin
        e_wren = 1'b1; e_addr = bus.i_alu_rd; e_data = bus.i_alu_data;
      end else if (exp_q.size() > 0) begin
        head = exp_q[0];
        e_wren = (head[36:32] != 5'd0); e_addr = head[36:32]; e_data = head[31:0];
      end

      @(negedge clk);
      total_cnt++; if (bus.o_rd_wren !== e_wren || (e_wren && (bus.o_rd_addr !== e_addr || bus.o_rd_data !== e_data)))
        $display("FAIL rnd_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc,
                 bus.o_rd_wren, bus.o_rd_addr, bus.o_rd_data, e_wren, e_addr, e_data); else pass_cnt++;
      total_cnt++; if (bus.o_ll_ready !== ready_m || stall !== stall_m)
        $display("FAIL rnd_ready_stall cyc=%0d got=%b/%b exp=%b/%b", cyc, bus.o_ll_ready, stall, ready_m, stall_m); else pass_cnt++;

      if (!alu_win_m && exp_q.size() > 0) begin
        head = exp_q.pop_front();
        if (head[36:32] != 5'd0) pend_m[head[36:32]] = 1'b0;
      end
      if (prod_valid && ready_m) begin
        exp_q.push_back({prod_rd, prod_data});
        prod_valid = 1'b0;
      end
      if (issue_valid && issue_rd != 5'd0 && !stall_m) begin
        pend_m[issue_rd] = 1'b1;
        iss_q.push_back(issue_rd);
      end
      tick();
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ll_write();
    test_alu_priority();
    test_fifo_full();
    test_x0();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
